// File: rtl/bcd_display_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_counter_pkg
//  Description : Shared definitions for the BCD display counter: converter
//                state encodings, the blank segment code and the active-low
//                seven-segment table for the decimal digits 0..9.
//                Segment order is {g,f,e,d,c,b,a}; a 0 lights a segment.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_display_counter_pkg;

    // Converter sequencer states
    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_DONE  = 2'd2
    } conv_state_e;

    // All segments off
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns, entry 9 first so that SEG_TABLE[n] is digit n
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    // Non-decimal codes cannot be produced by the converter; show them blank
    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            seg = SEG_TABLE[digit];
        end
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/BCD2SevenSegment.sv
`default_nettype none
// ============================================================================
//  Module      : BCD2SevenSegment
//  Description : One-digit BCD to active-low seven-segment encoder.
//  Ports       : i_bcd [3:0]  BCD digit
//                o_seg [6:0]  {g,f,e,d,c,b,a}, active low; codes above 9 blank
//  Revision    : 1.0 - initial release
// ============================================================================
module BCD2SevenSegment
    import bcd_display_counter_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    assign o_seg = seg_encode(i_bcd);

endmodule
`default_nettype wire

// File: rtl/binary_to_bcd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : binary_to_bcd_seq
//  Description : Sequential double-dabble binary to BCD converter. Samples
//                the input in IDLE, runs WIDTH shift/add-3 steps, publishes
//                the result in DONE and returns to IDLE, so a new result
//                appears every WIDTH+2 cycles.
//  Ports       : clk        system clock
//                rst_n      asynchronous reset, active low
//                i_bin      binary value sampled in IDLE
//                o_bcd      registered BCD result, digit 0 in [3:0]
//                o_scratch  working BCD digits (final value while o_load=1)
//                o_load     high during DONE: o_scratch is being published
//                o_busy     converter not in IDLE
//                o_valid    one-cycle pulse together with the o_bcd update
//  Revision    : 1.0 - initial release
// ============================================================================
module binary_to_bcd_seq
    import bcd_display_counter_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
)
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WIDTH-1:0]      i_bin,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic [4*DIGITS-1:0]   o_scratch,
    output logic                  o_load,
    output logic                  o_busy,
    output logic                  o_valid
);

    localparam int                  c_cnt_w = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0]  c_one   = c_cnt_w'(1);

    conv_state_e               state_q, state_d;
    logic [WIDTH-1:0]          shift_q, shift_d;
    logic [4*DIGITS-1:0]       scratch_q, scratch_d;
    logic [c_cnt_w-1:0]        cnt_q, cnt_d;
    logic [4*DIGITS-1:0]       bcd_q, bcd_d;
    logic                      busy_q, busy_d;
    logic                      valid_q, valid_d;
    logic [4*DIGITS-1:0]       w_adj;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        valid_d   = 1'b0;

        // Add-3 correction: any digit >= 5 would exceed 9 after doubling
        w_adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end

        case (state_q)
            CONV_IDLE: begin
                shift_d   = i_bin;
                scratch_d = '0;
                cnt_d     = '0;
                state_d   = CONV_SHIFT;
            end
            CONV_SHIFT: begin
                {scratch_d, shift_d} = {w_adj, shift_q} << 1;
                cnt_d = cnt_q + c_one;
                if (cnt_q == c_last) begin
                    state_d = CONV_DONE;
                end
            end
            CONV_DONE: begin
                bcd_d   = scratch_q;
                valid_d = 1'b1;
                state_d = CONV_IDLE;
            end
            default: begin
                state_d = CONV_IDLE;
            end
        endcase

        busy_d = (state_d != CONV_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= CONV_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            busy_q    <= busy_d;
            valid_q   <= valid_d;
        end
    end

    assign o_bcd     = bcd_q;
    assign o_scratch = scratch_q;
    assign o_load    = (state_q == CONV_DONE);
    assign o_busy    = busy_q;
    assign o_valid   = valid_q;

endmodule
`default_nettype wire

// File: rtl/bcd_display_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_display_counter
//  Description : Up/down modulo counter with saturating parallel load and a
//                cascade terminal-count, continuously shown on seven-segment
//                displays through a sequential binary-to-BCD converter.
//  Ports       : CLK    system clock (posedge)
//                R      asynchronous reset, active low
//                E      count enable
//                UP     1 = count up, 0 = count down
//                LD     synchronous load (has priority over E)
//                D      load value, saturated to MAX_COUNT
//                Q      current count
//                TC     terminal count (combinational)
//                bcd    BCD of the last converted sample, digit 0 in [3:0]
//                HEX    active-low {g,f,e,d,c,b,a} per digit, digit 0 in [6:0]
//                BUSY   converter not idle
//                VALID  one-cycle pulse when bcd/HEX update
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_display_counter
    import bcd_display_counter_pkg::*;
#(
    parameter int              WIDTH     = 16,
    parameter int              DIGITS    = 5,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter int              BLANK_LZ  = 0
)
(
    input  logic                  CLK,
    input  logic                  R,
    input  logic                  E,
    input  logic                  UP,
    input  logic                  LD,
    input  logic [WIDTH-1:0]      D,
    output logic [WIDTH-1:0]      Q,
    output logic                  TC,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   HEX,
    output logic                  BUSY,
    output logic                  VALID
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX_COUNT);
    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [WIDTH-1:0]     q_q, q_d;
    logic [7*DIGITS-1:0]  hex_q, hex_d;
    logic [4*DIGITS-1:0]  w_scratch;
    logic                 w_load;
    logic [7*DIGITS-1:0]  w_seg;
    logic [DIGITS:0]      w_lz;
    logic [7*DIGITS-1:0]  w_hex_new;

    // ------------------------------------------------------------------
    // Counter
    // ------------------------------------------------------------------
    always_comb begin
        q_d = q_q;
        if (LD) begin
            q_d = (D > c_max) ? c_max : D;
        end else if (E) begin
            if (UP) begin
                q_d = (q_q == c_max) ? '0 : q_q + c_one;
            end else begin
                q_d = (q_q == '0) ? c_max : q_q - c_one;
            end
        end
    end

    assign TC = E & ~LD & (UP ? (q_q == c_max) : (q_q == '0));

    // ------------------------------------------------------------------
    // Converter
    // ------------------------------------------------------------------
    binary_to_bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk       (CLK),
        .rst_n     (R),
        .i_bin     (q_q),
        .o_bcd     (bcd),
        .o_scratch (w_scratch),
        .o_load    (w_load),
        .o_busy    (BUSY),
        .o_valid   (VALID)
    );

    // ------------------------------------------------------------------
    // Segment encoding of the digits about to be published
    // ------------------------------------------------------------------
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        BCD2SevenSegment u_seg (
            .i_bcd (w_scratch[4*i +: 4]),
            .o_seg (w_seg[7*i +: 7])
        );
    end

    // w_lz[i] is set when digit i and every digit above it are zero
    always_comb begin
        w_lz         = '0;
        w_lz[DIGITS] = 1'b1;
        w_hex_new    = w_seg;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_lz[i] = w_lz[i+1] & (w_scratch[4*i +: 4] == 4'd0);
            if ((BLANK_LZ != 0) && (i > 0) && w_lz[i]) begin
                w_hex_new[7*i +: 7] = SEG_BLANK;
            end
        end
    end

    // HEX follows bcd on the same edge so both always show one sample
    always_comb begin
        hex_d = hex_q;
        if (w_load) begin
            hex_d = w_hex_new;
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            q_q <= '0;
            for (int i = 0; i < DIGITS; i++) begin
                hex_q[7*i +: 7] <= ((i == 0) || (BLANK_LZ == 0)) ? SEG_TABLE[0] : SEG_BLANK;
            end
        end else begin
            q_q   <= q_d;
            hex_q <= hex_d;
        end
    end

    assign Q   = q_q;
    assign HEX = hex_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_display_counter
//  Description : Self-checking bench for bcd_display_counter. Three instances
//                share the control inputs: A (16 bit, 5 digits), B (modulo 60,
//                6 bit, 2 digits) and C (16 bit, 5 digits, leading-zero
//                blanking). A per-instance reference model tracks count,
//                sample schedule and expected displays.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bcd_display_counter;

    logic        CLK = 1'b0;
    logic        R   = 1'b1;
    logic        E   = 1'b0;
    logic        UP  = 1'b1;
    logic        LD  = 1'b0;
    logic [15:0] d_a = '0;
    logic [5:0]  d_b = '0;
    logic [15:0] d_c = '0;

    logic [15:0] q_a;  logic tc_a; logic [19:0] bcd_a; logic [34:0] hex_a; logic busy_a; logic valid_a;
    logic [5:0]  q_b;  logic tc_b; logic [7:0]  bcd_b; logic [13:0] hex_b; logic busy_b; logic valid_b;
    logic [15:0] q_c;  logic tc_c; logic [19:0] bcd_c; logic [34:0] hex_c; logic busy_c; logic valid_c;

    int n_chk = 0;
    int n_err = 0;

    int          cfg_w   [3] = '{16, 6, 16};
    int          cfg_n   [3] = '{5, 2, 5};
    int unsigned cfg_max [3] = '{65535, 59, 65535};
    int          cfg_blz [3] = '{0, 0, 1};

    int unsigned m_q    [3];
    int unsigned m_k    [3];
    int unsigned m_samp [3];
    logic [19:0] m_bcd  [3];

    always #5 CLK = ~CLK;

    bcd_display_counter #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(0)) u_a (
        .CLK(CLK), .R(R), .E(E), .UP(UP), .LD(LD), .D(d_a), .Q(q_a), .TC(tc_a),
        .bcd(bcd_a), .HEX(hex_a), .BUSY(busy_a), .VALID(valid_a));

    bcd_display_counter #(.WIDTH(6), .DIGITS(2), .MAX_COUNT(59), .BLANK_LZ(0)) u_b (
        .CLK(CLK), .R(R), .E(E), .UP(UP), .LD(LD), .D(d_b), .Q(q_b), .TC(tc_b),
        .bcd(bcd_b), .HEX(hex_b), .BUSY(busy_b), .VALID(valid_b));

    bcd_display_counter #(.WIDTH(16), .DIGITS(5), .BLANK_LZ(1)) u_c (
        .CLK(CLK), .R(R), .E(E), .UP(UP), .LD(LD), .D(d_c), .Q(q_c), .TC(tc_c),
        .bcd(bcd_c), .HEX(hex_c), .BUSY(busy_c), .VALID(valid_c));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [6:0] seg_of(input logic [3:0] dg);
        case (dg)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [19:0] to_bcd(input int unsigned v, input int nd);
        logic [19:0] r;
        int unsigned t;
        r = '0;
        t = v;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [34:0] exp_hex(input logic [19:0] b, input int nd, input int blz);
        logic [34:0] h;
        bit          lead;
        logic [3:0]  dg;
        h    = '0;
        lead = 1'b1;
        for (int i = nd - 1; i >= 0; i--) begin
            dg   = b[4*i +: 4];
            lead = lead && (dg == 4'd0);
            if (blz != 0 && i > 0 && lead) h[7*i +: 7] = 7'h7F;
            else                           h[7*i +: 7] = seg_of(dg);
        end
        return h;
    endfunction

    task automatic model_reset_all();
        for (int i = 0; i < 3; i++) begin
            m_q[i] = 0; m_k[i] = 0; m_samp[i] = 0; m_bcd[i] = '0;
        end
    endtask

    // One rising edge: conversion samples Q every W+2 edges starting with the
    // first edge after reset; the result appears W+1 edges after its sample.
    task automatic model_edge();
        int unsigned dv;
        int unsigned p;
        for (int i = 0; i < 3; i++) begin
            if (!R) begin
                m_q[i] = 0; m_k[i] = 0; m_samp[i] = 0; m_bcd[i] = '0;
            end else begin
                p = cfg_w[i] + 2;
                m_k[i]++;
                if (m_k[i] % p == 1) m_samp[i] = m_q[i];
                if (m_k[i] % p == 0) m_bcd[i] = to_bcd(m_samp[i], cfg_n[i]);
                dv = (i == 0) ? d_a : (i == 1) ? 32'(d_b) : d_c;
                if (LD)      m_q[i] = (dv > cfg_max[i]) ? cfg_max[i] : dv;
                else if (E) begin
                    if (UP) m_q[i] = (m_q[i] == cfg_max[i]) ? 0 : m_q[i] + 1;
                    else    m_q[i] = (m_q[i] == 0) ? cfg_max[i] : m_q[i] - 1;
                end
            end
        end
    endtask

    function automatic logic exp_tc(input int i);
        return E & ~LD & (UP ? (m_q[i] == cfg_max[i]) : (m_q[i] == 0));
    endfunction

    function automatic logic exp_busy(input int i);
        return (m_k[i] % (cfg_w[i] + 2)) != 0;
    endfunction

    function automatic logic get_valid(input int i);
        return (i == 0) ? valid_a : (i == 1) ? valid_b : valid_c;
    endfunction

    task automatic check_tc();
        check("tc_a", 64'(tc_a), 64'(exp_tc(0)));
        check("tc_b", 64'(tc_b), 64'(exp_tc(1)));
        check("tc_c", 64'(tc_c), 64'(exp_tc(2)));
    endtask

    task automatic check_all();
        check("q_a",     64'(q_a),     64'(m_q[0]));
        check("bcd_a",   64'(bcd_a),   64'(m_bcd[0]));
        check("hex_a",   64'(hex_a),   64'(exp_hex(m_bcd[0], 5, 0)));
        check("busy_a",  64'(busy_a),  64'(exp_busy(0)));
        check("valid_a", 64'(valid_a), 64'(!exp_busy(0) && m_k[0] != 0));
        check("q_b",     64'(q_b),     64'(m_q[1]));
        check("bcd_b",   64'(bcd_b),   64'(m_bcd[1][7:0]));
        check("hex_b",   64'(hex_b),   64'(exp_hex(m_bcd[1], 2, 0)));
        check("busy_b",  64'(busy_b),  64'(exp_busy(1)));
        check("valid_b", 64'(valid_b), 64'(!exp_busy(1) && m_k[1] != 0));
        check("q_c",     64'(q_c),     64'(m_q[2]));
        check("bcd_c",   64'(bcd_c),   64'(m_bcd[2]));
        check("hex_c",   64'(hex_c),   64'(exp_hex(m_bcd[2], 5, 1)));
        check("busy_c",  64'(busy_c),  64'(exp_busy(2)));
        check("valid_c", 64'(valid_c), 64'(!exp_busy(2) && m_k[2] != 0));
    endtask

    // Called at a falling edge with inputs already set; returns at the next one
    task automatic cycle();
        #1;
        check_tc();
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
        check_all();
    endtask

    task automatic wait_valid(input int idx, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!get_valid(idx) && n < 40);
        if (!get_valid(idx)) check("valid_timeout", 64'(0), 64'(1));
    endtask

    task automatic load_all(input logic [15:0] va, input logic [5:0] vb, input logic [15:0] vc);
        LD = 1'b1; E = 1'b0; d_a = va; d_b = vb; d_c = vc;
        cycle();
        LD = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (limit 1000000 ns)");
        $fatal(1);
    end

    initial begin
        int n;
        model_reset_all();
        #2;
        R = 1'b0;
        @(negedge CLK);

        // Reset held with E=1
        E = 1'b1; UP = 1'b1;
        repeat (3) cycle();
        check("rst_q_a",    64'(q_a),    64'(0));
        check("rst_busy_a", 64'(busy_a), 64'(0));
        check("rst_hex_c",  64'(hex_c),  {29'd0, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'b1000000});
        R = 1'b1; E = 1'b0;
        cycle();
        check("busy_rise_a", 64'(busy_a), 64'(1));

        // Load and convert 12345
        load_all(16'd12345, 6'd45, 16'd12345);
        wait_valid(0, n);
        wait_valid(0, n);
        check("bcd_12345",  64'(bcd_a),      64'(20'h12345));
        check("hex0_five",  64'(hex_a[6:0]), 64'(7'b0010010));
        cycle();
        check("valid_width", 64'(valid_a), 64'(0));
        wait_valid(0, n);
        check("valid_period", 64'(n + 1), 64'(18));

        // Wrap up at 65535 / 59
        load_all(16'd65535, 6'd59, 16'd65535);
        E = 1'b1; UP = 1'b1;
        #1;
        check("wrap_tc_a", 64'(tc_a), 64'(1));
        check("wrap_tc_b", 64'(tc_b), 64'(1));
        cycle();
        check("wrap_q_a",  64'(q_a),  64'(0));
        check("wrap_tc_a_after", 64'(tc_a), 64'(0));
        check("wrap_q_b",  64'(q_b),  64'(0));

        // Modulo down from 0
        load_all(16'd0, 6'd0, 16'd0);
        E = 1'b1; UP = 1'b0;
        #1;
        check("down_tc_b", 64'(tc_b), 64'(1));
        cycle();
        E = 1'b0;
        check("down_q_b", 64'(q_b), 64'(59));
        check("down_q_a", 64'(q_a), 64'(65535));
        wait_valid(1, n);
        wait_valid(1, n);
        check("bcd_59", 64'(bcd_b), 64'(8'h59));
        load_all(16'd7, 6'd63, 16'd7);
        check("sat_q_b", 64'(q_b), 64'(59));

        // Leading-zero blanking with 42
        load_all(16'd42, 6'd42, 16'd42);
        wait_valid(2, n);
        wait_valid(2, n);
        check("blank_hi", 64'(hex_c[34:14]), 64'(21'h1FFFFF));
        check("blank_4",  64'(hex_c[13:7]),  64'(7'b0011001));
        check("blank_2",  64'(hex_c[6:0]),   64'(7'b0100100));

        // Reset in the middle of a conversion
        wait_valid(0, n);
        repeat (7) cycle();
        check("mid_busy_before", 64'(busy_a), 64'(1));
        R = 1'b0;
        model_reset_all();
        #1;
        check("mid_busy",  64'(busy_a),  64'(0));
        check("mid_valid", 64'(valid_a), 64'(0));
        check("mid_bcd",   64'(bcd_a),   64'(0));
        @(negedge CLK);
        cycle();
        R = 1'b1;
        cycle();
        check("restart_busy", 64'(busy_a), 64'(1));
        wait_valid(0, n);
        check("restart_lat", 64'(n + 1), 64'(18));

        // Randomised traffic
        for (int t = 0; t < 500; t++) begin
            E   = ($urandom_range(0, 3) != 0);
            UP  = 1'($urandom);
            LD  = ($urandom_range(0, 15) == 0);
            d_a = 16'($urandom);
            d_b = 6'($urandom);
            d_c = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 120)) : 16'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                R = 1'b0;
                model_reset_all();
            end else begin
                R = 1'b1;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
